// File: rtl/aes_pkg.sv
// Shared types and constants for the AES block packer.
// Block geometry, packer states and core mode encodings.
package aes_pkg;

  localparam int AES_BLK_BYTES = 16;
  localparam int AES_BLK_W     = 128;

  localparam logic AES_ENC = 1'b0;
  localparam logic AES_DEC = 1'b1;

  typedef enum logic [1:0] {
    S_FILL,
    S_ISSUE,
    S_WAIT
  } state_t;

  // Write byte b at big-endian byte slot idx of blk.
  function automatic logic [AES_BLK_W-1:0] put_byte(
    input logic [AES_BLK_W-1:0] blk,
    input logic [3:0]           idx,
    input logic [7:0]           b
  );
    logic [AES_BLK_W-1:0] r;
    r = blk;
    r[AES_BLK_W-1-8*int'(idx) -: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/aes_pkcs7_pad.sv
// Combinational tail filler for a partial AES block.
// Keeps bytes 0..n-1; bytes n..15 become 16-n or zero.
module aes_pkcs7_pad
  import aes_pkg::*;
#(
  parameter bit PAD_EN = 1'b1
) (
  input  logic [AES_BLK_W-1:0] i_Blk,
  input  logic [3:0]           i_N,
  output logic [AES_BLK_W-1:0] o_Blk
);

  logic [7:0] fill;

  // n=0 yields a full block of 0x10, reused for the trailing pad block.
  always_comb begin
    fill  = PAD_EN ? (8'd16 - {4'd0, i_N}) : 8'd0;
    o_Blk = i_Blk;
    for (int k = 0; k < AES_BLK_BYTES; k++) begin
      if (k >= int'(i_N)) begin
        o_Blk[AES_BLK_W-1-8*k -: 8] = fill;
      end
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// Byte-stream to 128-bit block packer feeding the AES core.
// One block in flight; source is stalled until the core is done.
module aes_block_packer
  import aes_pkg::*;
#(
  parameter bit PAD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic [7:0]           i_Byte,
  input  logic                 i_Byte_Valid,
  input  logic                 i_Byte_Last,
  output logic                 o_Byte_Ready,
  input  logic                 i_Mode,
  output logic [AES_BLK_W-1:0] o_Din,
  output logic                 o_Din_En,
  output logic                 o_Mode,
  input  logic                 i_Core_Done,
  output logic                 o_Busy,
  output logic [CNT_W-1:0]     o_Blk_Cnt
);

  state_t               state_q;
  logic [3:0]           idx_q;
  logic                 pad_pend_q;
  logic [AES_BLK_W-1:0] fill_q;
  logic [AES_BLK_W-1:0] merged;
  logic [AES_BLK_W-1:0] padded;
  logic [3:0]           pad_n;
  logic                 xfer;
  logic                 full;

  assign o_Byte_Ready = i_Rst_n && (state_q == S_FILL);
  assign xfer         = i_Byte_Valid && o_Byte_Ready;
  assign full         = (idx_q == 4'd15);
  assign merged       = put_byte(fill_q, idx_q, i_Byte);

  // In WAIT the count is 0 so the filler emits 16 x 0x10.
  assign pad_n = (state_q == S_WAIT) ? 4'd0 : idx_q + 4'd1;

  aes_pkcs7_pad #(
    .PAD_EN(PAD_EN)
  ) u_pad (
    .i_Blk(merged),
    .i_N  (pad_n),
    .o_Blk(padded)
  );

  // Fill / issue / wait sequencer with registered core-side outputs.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q    <= S_FILL;
      idx_q      <= 4'd0;
      pad_pend_q <= 1'b0;
      fill_q     <= '0;
      o_Din      <= '0;
      o_Din_En   <= 1'b0;
      o_Mode     <= AES_ENC;
      o_Busy     <= 1'b0;
      o_Blk_Cnt  <= '0;
    end else begin
      o_Din_En <= 1'b0;
      unique case (state_q)
        S_FILL: begin
          if (xfer) begin
            if (idx_q == 4'd0) begin
              o_Mode <= i_Mode;
            end
            if (full || i_Byte_Last) begin
              o_Din      <= full ? merged : padded;
              o_Din_En   <= 1'b1;
              pad_pend_q <= PAD_EN && full && i_Byte_Last;
              fill_q     <= '0;
              idx_q      <= 4'd0;
              state_q    <= S_ISSUE;
            end else begin
              fill_q <= merged;
              idx_q  <= idx_q + 4'd1;
            end
          end
        end
        S_ISSUE: begin
          o_Busy    <= 1'b1;
          o_Blk_Cnt <= o_Blk_Cnt + CNT_W'(1);
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (i_Core_Done) begin
            o_Busy <= 1'b0;
            if (pad_pend_q) begin
              o_Din      <= padded;
              o_Din_En   <= 1'b1;
              pad_pend_q <= 1'b0;
              state_q    <= S_ISSUE;
            end else begin
              fill_q  <= '0;
              idx_q   <= 4'd0;
              state_q <= S_FILL;
            end
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

endmodule
